// File: rtl/nt_subckt_bist_driver_pkg.sv
// ============================================================================
// nt_bist_pkg : shared types and constants for the CUT BIST driver
// Revision    : 1.0
// ============================================================================
`default_nettype none

package nt_bist_pkg;

  localparam int          SIG_W         = 16;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;  // x^16+x^14+x^13+x^11+1
  localparam logic [15:0] SEED_ZERO_SUB = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET_DUT = 3'd1,
    ST_RUN       = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/nt_subckt_bist_driver_if.sv
// ============================================================================
// nt_subckt_bist_driver_if : harness-side bus of the CUT BIST driver
// Revision                 : 1.0
// ============================================================================
`default_nettype none

interface nt_subckt_bist_driver_if
  import nt_bist_pkg::*;
#(
  parameter int N_IN  = 7,
  parameter int N_OUT = 1
);

  logic             start;
  logic [SIG_W-1:0] seed;
  logic [SIG_W-1:0] golden;
  logic [N_IN-1:0]  stim;
  logic             stim_valid;
  logic             dut_rst;
  logic [N_OUT-1:0] resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;

  modport master (
    input  start, seed, golden, resp,
    output stim, stim_valid, dut_rst, busy, done, pass, signature
  );

  modport slave (
    output start, seed, golden, resp,
    input  stim, stim_valid, dut_rst, busy, done, pass, signature
  );

endinterface

`default_nettype wire

// File: rtl/nt_subckt_bist_driver_lfsr16.sv
// ============================================================================
// nt_bist_lfsr16 : 16-bit Fibonacci shift register with load, enable and
//                  parallel XOR input (generator when xor_in=0, else MISR)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module nt_bist_lfsr16
  import nt_bist_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        load,
  input  wire logic [15:0] load_val,
  input  wire logic        en,
  input  wire logic [15:0] xor_in,
  output logic      [15:0] q
);

  logic [15:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load)    val_d = load_val;
    else if (en) val_d = lfsr_step(val_q) ^ xor_in;
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= 16'h0000;
    else     val_q <= val_d;
  end

  assign q = val_q;

endmodule

`default_nettype wire

// File: rtl/nt_subckt_bist_driver.sv
// ============================================================================
// nt_subckt_bist_driver : LFSR stimulus + MISR compaction BIST end for a CUT
// Revision              : 1.0
// ============================================================================
`default_nettype none

module nt_subckt_bist_driver
  import nt_bist_pkg::*;
#(
  parameter int N_IN      = 7,
  parameter int N_OUT     = 1,
  parameter int VEC_COUNT = 256,
  parameter int LAT       = 2
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  nt_subckt_bist_driver_if.master bus
);

  localparam int CNT_W = $clog2(VEC_COUNT + LAT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic             stim_valid_q, stim_valid_d;
  logic             dut_rst_q, dut_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [15:0]      signature_q, signature_d;
  logic [LAT-1:0]   cap_sr_q, cap_sr_d;

  logic        start_acc, gen_en, misr_en;
  logic [15:0] seed_eff, resp_ext, gen_q, misr_q, misr_after;
  logic        unused_gen_bits;

  nt_bist_lfsr16 u_gen (
    .clk(CLK), .rst(RST), .load(start_acc), .load_val(seed_eff),
    .en(gen_en), .xor_in(16'h0000), .q(gen_q)
  );

  nt_bist_lfsr16 u_misr (
    .clk(CLK), .rst(RST), .load(start_acc), .load_val(16'h0000),
    .en(misr_en), .xor_in(resp_ext), .q(misr_q)
  );

  assign unused_gen_bits = ^gen_q;

  always_comb begin
    start_acc  = (state_q == ST_IDLE) && bus.start;
    seed_eff   = (bus.seed == 16'h0000) ? SEED_ZERO_SUB : bus.seed;
    resp_ext   = 16'(bus.resp);
    misr_en    = cap_sr_q[LAT-1];
    // Value the MISR will hold after this edge; captured into signature on entering DONE.
    misr_after = misr_en ? (lfsr_step(misr_q) ^ resp_ext) : misr_q;

    state_d     = state_q;
    cnt_d       = cnt_q;
    gen_en      = 1'b0;
    signature_d = signature_q;
    pass_d      = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_RESET_DUT;
          cnt_d       = '0;
          signature_d = 16'h0000;
          pass_d      = 1'b0;
        end
      end
      ST_RESET_DUT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RUN;
          cnt_d   = CNT_W'(1);
          gen_en  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(VEC_COUNT)) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          gen_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(LAT)) begin
          state_d     = ST_DONE;
          signature_d = misr_after;
          pass_d      = (misr_after == bus.golden);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    stim_d       = gen_en ? gen_q[N_IN-1:0] : '0;
    stim_valid_d = gen_en;
    dut_rst_d    = !((state_d == ST_RUN) || (state_d == ST_DRAIN));
    busy_d       = (state_d == ST_RESET_DUT) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d       = (state_d == ST_DONE);
    cap_sr_d     = start_acc ? '0 : LAT'({cap_sr_q, stim_valid_q});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      stim_q       <= '0;
      stim_valid_q <= 1'b0;
      dut_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      signature_q  <= 16'h0000;
      cap_sr_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stim_q       <= stim_d;
      stim_valid_q <= stim_valid_d;
      dut_rst_q    <= dut_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      signature_q  <= signature_d;
      cap_sr_q     <= cap_sr_d;
    end
  end

  assign bus.stim       = stim_q;
  assign bus.stim_valid = stim_valid_q;
  assign bus.dut_rst    = dut_rst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.signature  = signature_q;

endmodule

`default_nettype wire
